// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared opcode constants, FSM state type and iteration count
// for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  localparam logic [2:0] MD_MUL    = 3'd0;
  localparam logic [2:0] MD_MULH   = 3'd1;
  localparam logic [2:0] MD_MULHSU = 3'd2;
  localparam logic [2:0] MD_MULHU  = 3'd3;
  localparam logic [2:0] MD_DIV    = 3'd4;
  localparam logic [2:0] MD_DIVU   = 3'd5;
  localparam logic [2:0] MD_REM    = 3'd6;
  localparam logic [2:0] MD_REMU   = 3'd7;

  localparam int MD_ITERS = 32;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

endpackage

// File: rtl/muldiv_divider.sv
// muldiv_divider: unsigned restoring divider datapath, one quotient bit per
// step. Operates on magnitudes; sign fix-up and special cases live in the top.
// Only present when MULDIV_DIV_EN is defined.
`ifdef MULDIV_DIV_EN
module muldiv_divider #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient_next,
  output logic [XLEN-1:0] remainder_next
);

  logic [XLEN-1:0] quo_reg;
  logic [XLEN-1:0] rem_reg;
  logic [XLEN-1:0] div_reg;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    shifted = {rem_reg, quo_reg[XLEN-1]};
    diff    = shifted - {1'b0, div_reg};
    if (!diff[XLEN]) begin
      remainder_next = diff[XLEN-1:0];
      quotient_next  = {quo_reg[XLEN-2:0], 1'b1};
    end else begin
      remainder_next = shifted[XLEN-1:0];
      quotient_next  = {quo_reg[XLEN-2:0], 1'b0};
    end
  end

  // Load operands on accept, then advance one step per CALC cycle.
  always_ff @(posedge clk) begin
    if (load) begin
      quo_reg <= dividend;
      rem_reg <= '0;
      div_reg <= divisor;
    end else if (step) begin
      quo_reg <= quotient_next;
      rem_reg <= remainder_next;
    end
  end

endmodule
`endif

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide with fixed 33-cycle latency.
// Optional divider enabled by defining MULDIV_DIV_EN; without it, divide
// opcodes are rejected with a one-cycle illegal pulse.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [4:0]      rd,
  input  logic [XLEN-1:0] rs1_value,
  input  logic [XLEN-1:0] rs2_value,
  output logic            busy,
  output logic            we,
  output logic [4:0]      wr_address,
  output logic [XLEN-1:0] wr_value,
  output logic            illegal
);

  localparam logic [5:0] LAST_ITER = 6'(MD_ITERS - 1);

  md_state_t         state_reg, state_next;
  logic [5:0]        cnt_reg;
  logic [2:0]        funct3_reg;
  logic [4:0]        rd_reg;
  logic [XLEN-1:0]   a_mag_reg;
  logic [2*XLEN-1:0] acc_reg, acc_next;
  logic              neg_reg;
  logic              start_accept, illegal_next, last_step;
  logic              sign_a, sign_b, a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN:0]     acc_sum;
  logic [2*XLEN-1:0] prod_signed;
  logic [XLEN-1:0]   result;
  logic              we_reg, illegal_reg;
  logic [4:0]        wr_address_reg;
  logic [XLEN-1:0]   wr_value_reg;

`ifdef MULDIV_DIV_EN
  logic            a_neg_reg, b_zero_reg;
  logic [XLEN-1:0] quo_next, rem_next, dividend_raw;
`endif

  // Operand signedness and magnitude conversion from the incoming request.
  always_comb begin
    sign_a = (funct3 == MD_MULH) || (funct3 == MD_MULHSU) ||
             (funct3 == MD_DIV)  || (funct3 == MD_REM);
    sign_b = (funct3 == MD_MULH) || (funct3 == MD_DIV) || (funct3 == MD_REM);
    a_neg  = sign_a & rs1_value[XLEN-1];
    b_neg  = sign_b & rs2_value[XLEN-1];
    a_mag  = a_neg ? -rs1_value : rs1_value;
    b_mag  = b_neg ? -rs2_value : rs2_value;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_reg <= MD_IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic and request acceptance.
  always_comb begin
    state_next   = state_reg;
    start_accept = 1'b0;
    illegal_next = 1'b0;
    case (state_reg)
      MD_IDLE: begin
        if (start) begin
`ifdef MULDIV_DIV_EN
          start_accept = 1'b1;
          state_next   = MD_CALC;
`else
          if (funct3[2]) begin
            illegal_next = 1'b1;
          end else begin
            start_accept = 1'b1;
            state_next   = MD_CALC;
          end
`endif
        end
      end
      MD_CALC: if (cnt_reg == LAST_ITER) state_next = MD_DONE;
      MD_DONE: state_next = MD_IDLE;
      default: state_next = MD_IDLE;
    endcase
  end

  assign last_step = (state_reg == MD_CALC) && (cnt_reg == LAST_ITER);

  // Radix-2 shift-add: low half starts as the multiplier, product builds in place.
  always_comb begin
    acc_sum     = {1'b0, acc_reg[2*XLEN-1:XLEN]} + (acc_reg[0] ? {1'b0, a_mag_reg} : '0);
    acc_next    = {acc_sum, acc_reg[XLEN-1:1]};
    prod_signed = neg_reg ? -acc_next : acc_next;
  end

  // Operand latch on accept and multiplier iteration during CALC.
  always_ff @(posedge clk) begin
    if (start_accept) begin
      funct3_reg <= funct3;
      rd_reg     <= rd;
      a_mag_reg  <= a_mag;
      acc_reg    <= {{XLEN{1'b0}}, b_mag};
      neg_reg    <= a_neg ^ b_neg;
      cnt_reg    <= '0;
    end else if (state_reg == MD_CALC) begin
      acc_reg <= acc_next;
      cnt_reg <= cnt_reg + 6'd1;
    end
  end

`ifdef MULDIV_DIV_EN
  muldiv_divider #(.XLEN(XLEN)) u_divider (
    .clk            (clk),
    .load           (start_accept),
    .step           (state_reg == MD_CALC),
    .dividend       (a_mag),
    .divisor        (b_mag),
    .quotient_next  (quo_next),
    .remainder_next (rem_next)
  );

  // Divide-specific flags kept for the final sign fix-up and special cases.
  always_ff @(posedge clk) begin
    if (start_accept) begin
      a_neg_reg  <= a_neg;
      b_zero_reg <= (rs2_value == '0);
    end
  end

  assign dividend_raw = a_neg_reg ? -a_mag_reg : a_mag_reg;
`endif

  // Final result selection from the last iteration's combinational outputs.
  // Signed overflow needs no substitution: |MIN|/1 = 0x80000000 with equal
  // signs and a zero remainder already yields the required values.
  always_comb begin
    result = prod_signed[XLEN-1:0];
    case (funct3_reg)
      MD_MUL:                       result = prod_signed[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: result = prod_signed[2*XLEN-1:XLEN];
`ifdef MULDIV_DIV_EN
      MD_DIV, MD_DIVU: result = b_zero_reg ? '1 : (neg_reg ? -quo_next : quo_next);
      MD_REM, MD_REMU: result = b_zero_reg ? dividend_raw : (a_neg_reg ? -rem_next : rem_next);
`endif
      default: result = prod_signed[XLEN-1:0];
    endcase
  end

  // Registered writeback outputs; they hold between operations.
  always_ff @(posedge clk) begin
    if (reset) begin
      we_reg         <= 1'b0;
      illegal_reg    <= 1'b0;
      wr_address_reg <= '0;
      wr_value_reg   <= '0;
    end else begin
      we_reg      <= 1'b0;
      illegal_reg <= illegal_next;
      if (last_step) begin
        we_reg         <= (rd_reg != 5'd0);
        wr_address_reg <= rd_reg;
        wr_value_reg   <= result;
      end
    end
  end

  assign busy       = (state_reg != MD_IDLE);
  assign we         = we_reg;
  assign illegal    = illegal_reg;
  assign wr_address = wr_address_reg;
  assign wr_value   = wr_value_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized self-checking bench for muldiv_unit against a
// plain-arithmetic RV32M reference model. Honours MULDIV_DIV_EN.
module tb_muldiv_unit;

`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk, reset, start;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic [31:0] rs1_value, rs2_value;
  logic        busy, we, illegal;
  logic [4:0]  wr_address;
  logic [31:0] wr_value;

  int checks = 0;
  int errors = 0;

  muldiv_unit dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .funct3     (funct3),
    .rd         (rd),
    .rs1_value  (rs1_value),
    .rs2_value  (rs2_value),
    .busy       (busy),
    .we         (we),
    .wr_address (wr_address),
    .wr_value   (wr_value),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // RV32M semantics in 64-bit integer arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    int si, sj;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    si = a;
    sj = b;
    r  = '0;
    case (f3)
      3'd0: begin p = ua * ub; r = p[31:0];  end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * ub; r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
      3'd4: if (b == 0) r = 32'hFFFFFFFF;
            else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'h80000000;
            else r = si / sj;
      3'd5: r = (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: if (b == 0) r = a;
            else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'd0;
            else r = si % sj;
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  // One request; observes 36 cycles after the start edge. poke_at/rst_at
  // (0 = none) inject a second start or a reset at that cycle's edge.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [4:0] rdi,
                        input logic [31:0] a, input logic [31:0] b,
                        input int poke_at, input int rst_at);
    logic legal, eb, ew, ei;
    logic [31:0] exp_v;
    int busy_err, we_err, ill_err, hold_err;
    busy_err = 0; we_err = 0; ill_err = 0; hold_err = 0;
    legal = DIV_EN || !f3[2];
    exp_v = ref_model(f3, a, b);
    start = 1'b1; funct3 = f3; rd = rdi; rs1_value = a; rs2_value = b;
    for (int j = 1; j <= 36; j++) begin
      @(negedge clk);
      eb = legal && (j <= 33) && (rst_at == 0 || j <= rst_at);
      ew = legal && (rdi != 0) && (rst_at == 0) && (j == 33);
      ei = !legal && (j == 1);
      if (busy !== eb) busy_err++;
      if (we !== ew) we_err++;
      if (illegal !== ei) ill_err++;
      if (ew) begin
        check_eq({tag, ".wr_value"}, wr_value, exp_v);
        check_eq({tag, ".wr_address"}, {27'd0, wr_address}, {27'd0, rdi});
      end
      if (legal && rdi != 0 && rst_at == 0 && j > 33 && wr_value !== exp_v) hold_err++;
      if (rst_at > 0 && j == rst_at + 1) begin
        check_eq({tag, ".rst_wr_value"}, wr_value, 32'd0);
        check_eq({tag, ".rst_wr_address"}, {27'd0, wr_address}, 32'd0);
      end
      if (j == 1) begin
        start = 1'b0; funct3 = 3'($urandom); rd = 5'($urandom);
        rs1_value = $urandom; rs2_value = $urandom;
      end
      if (j == poke_at) begin
        start = 1'b1; funct3 = 3'($urandom); rd = 5'($urandom);
        rs1_value = $urandom; rs2_value = $urandom;
      end
      if (poke_at > 0 && j == poke_at + 1) start = 1'b0;
      if (j == rst_at) reset = 1'b1;
      if (rst_at > 0 && j == rst_at + 1) reset = 1'b0;
    end
    check_eq({tag, ".busy_profile"}, 32'(busy_err), 32'd0);
    check_eq({tag, ".we_profile"}, 32'(we_err), 32'd0);
    check_eq({tag, ".illegal_profile"}, 32'(ill_err), 32'd0);
    check_eq({tag, ".hold"}, 32'(hold_err), 32'd0);
    $display("op %s f3=%0d rd=%0d a=%h b=%h legal=%0d expect=%h", tag, f3, rdi, a, b, legal, exp_v);
  endtask

  logic [31:0] corners [6] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h2};

  function automatic logic [31:0] pick_operand();
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  initial begin
    clk = 1'b0; reset = 1'b1; start = 1'b0; funct3 = '0; rd = '0;
    rs1_value = '0; rs2_value = '0;
    repeat (3) @(negedge clk);
    check_eq("reset.busy", {31'd0, busy}, 32'd0);
    check_eq("reset.we", {31'd0, we}, 32'd0);
    check_eq("reset.illegal", {31'd0, illegal}, 32'd0);
    check_eq("reset.wr_address", {27'd0, wr_address}, 32'd0);
    check_eq("reset.wr_value", wr_value, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op("mul_7", 3'd0, 5'd5, 32'd7, 32'hFFFFFFFD, 0, 0);
    run_op("mulh_min", 3'd1, 5'd1, 32'h80000000, 32'h80000000, 0, 0);
    run_op("mulhu_max", 3'd3, 5'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
    run_op("mulhsu", 3'd2, 5'd3, 32'hFFFFFFFF, 32'd2, 0, 0);
    run_op("div_ovf", 3'd4, 5'd4, 32'h80000000, 32'hFFFFFFFF, 0, 0);
    run_op("rem_neg", 3'd6, 5'd6, 32'hFFFFFFF9, 32'd2, 0, 0);
    run_op("divu_zero", 3'd5, 5'd7, 32'd100, 32'd0, 0, 0);
    run_op("remu_zero", 3'd7, 5'd8, 32'd100, 32'd0, 0, 0);
    run_op("busy_poke", 3'd0, 5'd9, 32'h12345678, 32'h9ABCDEF0, 10, 0);
    run_op("mid_reset", DIV_EN ? 3'd4 : 3'd3, 5'd10, 32'hDEADBEEF, 32'd13, 0, 20);
    run_op("after_reset", 3'd1, 5'd11, 32'hCAFEF00D, 32'h87654321, 0, 0);
    run_op("rd_zero", 3'd0, 5'd0, 32'd3, 32'd4, 0, 0);

    for (int n = 0; n < 40; n++) begin
      run_op("rand", 3'($urandom_range(0, 7)), 5'($urandom), pick_operand(), pick_operand(), 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
